axi4_lite_slave_regs: RTL and testbench

//  AXI4-Lite responder (slave) that terminates master transactions into an internal register file
//  of Num_Regs x Data_Width registers. Sits at the far end of the bus from the AXI4-Lite master.

---
 rtl/axi4_lite_slave_regs_pkg.sv | 22 ++
 rtl/axi4_lite_regfile.sv | 35 +++
 rtl/axi4_lite_slave_regs.sv | 152 +++++++++++++++
 tb/tb_axi4_lite_slave_regs.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_slave_regs_pkg.sv
// Shared AXI4-Lite definitions: bus widths, response codes
// and the FSM state types used by the register slave.
package axi4_lite_Defs;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_REGS   = 16;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/axi4_lite_regfile.sv
// Register file with a byte-enabled write port and one
// combinational read port; synchronous reset to zero.
module axi4_lite_regfile #(
  parameter int Data_Width = 32,
  parameter int Num_Regs   = 16,
  parameter int Idx_W      = $clog2(Num_Regs),
  parameter int Strb_W     = Data_Width / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [Idx_W-1:0]      widx,
  input  logic [Strb_W-1:0]     wstrb,
  input  logic [Data_Width-1:0] wdata,
  input  logic [Idx_W-1:0]      ridx,
  output logic [Data_Width-1:0] rdata
);

  logic [Num_Regs-1:0][Data_Width-1:0] regs;

  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else if (we) begin
      for (int b = 0; b < Strb_W; b++) begin
        if (wstrb[b]) begin
          regs[widx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rdata = regs[ridx];

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave terminating independent write and read
// channels into a small register file.
module axi4_lite_slave_regs
  import axi4_lite_Defs::*;
#(
  parameter int Addr_Width = ADDR_WIDTH,
  parameter int Data_Width = DATA_WIDTH,
  parameter int Num_Regs   = NUM_REGS
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [Addr_Width-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [Data_Width-1:0]   WDATA,
  input  logic [Data_Width/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [Addr_Width-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [Data_Width-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int Idx_W  = $clog2(Num_Regs);
  localparam int Strb_W = Data_Width / 8;

  wr_state_t w_state;
  rd_state_t r_state;

  logic                  aw_held;
  logic                  w_held;
  logic [Addr_Width-1:0] aw_addr_q;
  logic [Data_Width-1:0] w_data_q;
  logic [Strb_W-1:0]     w_strb_q;

  logic                  aw_fire;
  logic                  w_fire;
  logic                  wr_go;
  logic                  wr_in;
  logic                  rd_in;
  logic [Addr_Width-1:0] aw_eff;
  logic [Data_Width-1:0] w_eff;
  logic [Strb_W-1:0]     s_eff;
  logic [Data_Width-1:0] rf_rdata;

  assign AWREADY = (w_state == W_IDLE) && !aw_held;
  assign WREADY  = (w_state == W_IDLE) && !w_held;
  assign ARREADY = (r_state == R_IDLE);

  assign aw_fire = AWVALID && AWREADY;
  assign w_fire  = WVALID && WREADY;
  assign wr_go   = (aw_held || aw_fire) && (w_held || w_fire);

  assign aw_eff = aw_held ? aw_addr_q : AWADDR;
  assign w_eff  = w_held ? w_data_q : WDATA;
  assign s_eff  = w_held ? w_strb_q : WSTRB;

  // Any address bit above the register index field is a decode error.
  assign wr_in = (aw_eff >> (Idx_W + 2)) == '0;
  assign rd_in = (ARADDR >> (Idx_W + 2)) == '0;

  axi4_lite_regfile #(
    .Data_Width(Data_Width),
    .Num_Regs  (Num_Regs)
  ) u_regfile (
    .clk  (ACLK),
    .rst  (ARESET),
    .we   (wr_go && wr_in),
    .widx (Idx_W'(aw_eff >> 2)),
    .wstrb(s_eff),
    .wdata(w_eff),
    .ridx (Idx_W'(ARADDR >> 2)),
    .rdata(rf_rdata)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state   <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      BVALID    <= 1'b0;
      BRESP     <= RESP_OKAY;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if (aw_fire) begin
            aw_held   <= 1'b1;
            aw_addr_q <= AWADDR;
          end
          if (w_fire) begin
            w_held   <= 1'b1;
            w_data_q <= WDATA;
            w_strb_q <= WSTRB;
          end
          if (wr_go) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            BVALID  <= 1'b1;
            BRESP   <= wr_in ? RESP_OKAY : RESP_SLVERR;
            w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read data is sampled before this edge's write lands: old value wins.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= R_IDLE;
      RVALID  <= 1'b0;
      RDATA   <= '0;
      RRESP   <= RESP_OKAY;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (ARVALID) begin
            RDATA   <= rd_in ? rf_rdata : '0;
            RRESP   <= rd_in ? RESP_OKAY : RESP_SLVERR;
            RVALID  <= 1'b1;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            RVALID  <= 1'b0;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed and randomized bench for axi4_lite_slave_regs
// against an array-based register model.
module tb_axi4_lite_slave_regs;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] model [16];

  axi4_lite_slave_regs dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .AWADDR (AWADDR),
    .AWVALID(AWVALID),
    .AWREADY(AWREADY),
    .WDATA  (WDATA),
    .WSTRB  (WSTRB),
    .WVALID (WVALID),
    .WREADY (WREADY),
    .BRESP  (BRESP),
    .BVALID (BVALID),
    .BREADY (BREADY),
    .ARADDR (ARADDR),
    .ARVALID(ARVALID),
    .ARREADY(ARREADY),
    .RDATA  (RDATA),
    .RRESP  (RRESP),
    .RVALID (RVALID),
    .RREADY (RREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return a < 32'd64;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0]  s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // mode 0: AW and W together, 1: AW first, 2: W first
  task automatic do_write(input logic [31:0] a,
                          input logic [31:0] d,
                          input logic [3:0]  s,
                          input int mode,
                          input int gap);
    BREADY = 1'b1;
    AWADDR = a;
    WDATA  = d;
    WSTRB  = s;
    if (mode == 0) begin
      AWVALID = 1'b1;
      WVALID  = 1'b1;
      tick();
      AWVALID = 1'b0;
      WVALID  = 1'b0;
    end else begin
      if (mode == 1) AWVALID = 1'b1;
      else WVALID = 1'b1;
      tick();
      AWVALID = 1'b0;
      WVALID  = 1'b0;
      AWADDR  = 32'hFFFF_FFFF;
      WDATA   = 32'h0BAD_0BAD;
      WSTRB   = 4'hF;
      for (int i = 0; i <= gap; i++) begin
        chk("bvalid_early", {31'b0, BVALID}, 32'd0);
        if (mode == 1) chk("awready_held", {31'b0, AWREADY}, 32'd0);
        else chk("wready_held", {31'b0, WREADY}, 32'd0);
        if (i < gap) tick();
      end
      AWADDR = a;
      WDATA  = d;
      WSTRB  = s;
      if (mode == 1) WVALID = 1'b1;
      else AWVALID = 1'b1;
      tick();
      AWVALID = 1'b0;
      WVALID  = 1'b0;
    end
    chk("bvalid", {31'b0, BVALID}, 32'd1);
    chk("bresp", {30'b0, BRESP}, in_rng(a) ? 32'd0 : 32'd2);
    if (in_rng(a)) model[a/4] = merge(model[a/4], d, s);
    tick();
    chk("bvalid_done", {31'b0, BVALID}, 32'd0);
  endtask

  task automatic do_read(input logic [31:0] a);
    RREADY  = 1'b1;
    ARADDR  = a;
    ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    chk("rvalid", {31'b0, RVALID}, 32'd1);
    chk("rdata", RDATA, in_rng(a) ? model[a/4] : 32'd0);
    chk("rresp", {30'b0, RRESP}, in_rng(a) ? 32'd0 : 32'd2);
    tick();
    chk("rvalid_done", {31'b0, RVALID}, 32'd0);
  endtask

  task automatic check_all();
    for (int i = 0; i < 16; i++) do_read(i * 4);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int idx;

    ARESET  = 1'b1;
    AWADDR  = '0;
    AWVALID = 1'b0;
    WDATA   = '0;
    WSTRB   = '0;
    WVALID  = 1'b0;
    BREADY  = 1'b0;
    ARADDR  = '0;
    ARVALID = 1'b0;
    RREADY  = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    tick();
    tick();
    ARESET = 1'b0;

    chk("rst_bvalid", {31'b0, BVALID}, 32'd0);
    chk("rst_rvalid", {31'b0, RVALID}, 32'd0);
    chk("rst_bresp", {30'b0, BRESP}, 32'd0);
    chk("rst_rresp", {30'b0, RRESP}, 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_awready", {31'b0, AWREADY}, 32'd1);
    chk("rst_wready", {31'b0, WREADY}, 32'd1);
    chk("rst_arready", {31'b0, ARREADY}, 32'd1);

    // same-cycle AW+W
    do_write(32'h04, 32'hDEAD_BEEF, 4'hF, 0, 0);
    do_read(32'h04);

    // W three cycles ahead of AW, partial strobe
    do_write(32'h10, 32'h1122_3344, 4'hF, 0, 0);
    do_write(32'h10, 32'h0000_AAAA, 4'h3, 2, 3);
    do_read(32'h10);
    chk("partial_strb", model[4], 32'h1122_AAAA);

    // AW ahead of W, zero strobe leaves register untouched
    do_write(32'h14, 32'hCAFE_F00D, 4'hF, 1, 2);
    do_write(32'h14, 32'h1234_5678, 4'h0, 0, 0);
    do_read(32'h14);

    // out of range access
    do_write(32'h100, 32'hFFFF_FFFF, 4'hF, 0, 0);
    do_read(32'h100);
    check_all();

    // stalled B and R channels
    BREADY  = 1'b0;
    RREADY  = 1'b0;
    AWADDR  = 32'h18;
    WDATA   = 32'hA5A5_5A5A;
    WSTRB   = 4'hF;
    ARADDR  = 32'h04;
    AWVALID = 1'b1;
    WVALID  = 1'b1;
    ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    d = model[1];
    model[6] = 32'hA5A5_5A5A;
    for (int i = 0; i < 5; i++) begin
      chk("stall_bvalid", {31'b0, BVALID}, 32'd1);
      chk("stall_bresp", {30'b0, BRESP}, 32'd0);
      chk("stall_rvalid", {31'b0, RVALID}, 32'd1);
      chk("stall_rdata", RDATA, d);
      chk("stall_rresp", {30'b0, RRESP}, 32'd0);
      chk("stall_awready", {31'b0, AWREADY}, 32'd0);
      chk("stall_wready", {31'b0, WREADY}, 32'd0);
      chk("stall_arready", {31'b0, ARREADY}, 32'd0);
      tick();
    end
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    BREADY  = 1'b1;
    RREADY  = 1'b1;
    tick();
    chk("unstall_bvalid", {31'b0, BVALID}, 32'd0);
    chk("unstall_rvalid", {31'b0, RVALID}, 32'd0);
    do_read(32'h18);

    // same-edge write and read of one register
    do_write(32'h08, 32'h77, 4'hF, 0, 0);
    BREADY  = 1'b1;
    RREADY  = 1'b1;
    AWADDR  = 32'h08;
    WDATA   = 32'h55;
    WSTRB   = 4'hF;
    ARADDR  = 32'h08;
    AWVALID = 1'b1;
    WVALID  = 1'b1;
    ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    ARVALID = 1'b0;
    chk("rw_old_rdata", RDATA, 32'h77);
    chk("rw_bvalid", {31'b0, BVALID}, 32'd1);
    model[2] = 32'h55;
    tick();
    do_read(32'h08);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 15);
      if ($urandom_range(0, 7) == 0)
        a = (32'h40 << $urandom_range(0, 25)) | (idx * 4);
      else
        a = (idx * 4) | $urandom_range(0, 3);
      do_write(a, $urandom, 4'($urandom_range(0, 15)),
               $urandom_range(0, 2), $urandom_range(0, 3));
      idx = $urandom_range(0, 15);
      do_read(idx * 4);
    end
    check_all();

    // reset while a response is pending
    BREADY  = 1'b0;
    AWADDR  = 32'h0C;
    WDATA   = 32'h1357_9BDF;
    WSTRB   = 4'hF;
    AWVALID = 1'b1;
    WVALID  = 1'b1;
    tick();
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    chk("pre_rst_bvalid", {31'b0, BVALID}, 32'd1);
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    chk("post_rst_bvalid", {31'b0, BVALID}, 32'd0);
    chk("post_rst_awready", {31'b0, AWREADY}, 32'd1);
    chk("post_rst_wready", {31'b0, WREADY}, 32'd1);
    chk("post_rst_arready", {31'b0, ARREADY}, 32'd1);
    tick();
    chk("post_rst_no_b", {31'b0, BVALID}, 32'd0);
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
